// File: rtl/mips_pkg.sv
// mips_pkg: shared front-end types and constants for the fetch PC stage.
//   pc_state_e      - PC stage FSM states (BOOT, RUN, HOLD)
//   PC_INC          - sequential fetch increment
//   DEFAULT_RESET_PC- default PC loaded on reset
//   align_word()    - clears the two byte-offset bits of an address
package mips_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned BOOT_CNT_W = 4;

  localparam logic [XLEN-1:0] PC_INC           = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pc_state_e;

  // Word-align an address by dropping the byte offset.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage : mips_pkg

// File: rtl/pc_adder.sv
// pc_adder: sequential next-PC adder, pc + PC_INC, wrapping modulo 2^32.
//   pc_in  - current fetch PC
//   sum_c  - pc_in + PC_INC (combinational)
module pc_adder
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] sum_c
);

  // Carry out of bit 31 is discarded, giving natural wraparound.
  assign sum_c = pc_in + PC_INC;

endmodule : pc_adder

// File: rtl/pc_stage.sv
// pc_stage: fetch program counter register with boot delay, stall and flush.
//   clk          - clock, all state updates on rising edge
//   rst          - asynchronous active-high reset
//   npc          - next-PC from the next-PC select mux
//   stall        - hold the PC this cycle
//   flush        - load npc and insert one bubble (wins over stall)
//   pc_out       - current fetch PC
//   pc_plus4     - pc_out + 4, feeds the sequential leg of the next-PC mux
//   valid_out    - pc_out is a fetch the IF/ID stage must accept
//   stalled_out  - high while the stage is in HOLD
//   misalign_out - sticky flag, a misaligned npc was loaded (only with
//                  PC_ALIGN_CHECK_EN defined; loads are then word-aligned)
module pc_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        valid_out,
`ifdef PC_ALIGN_CHECK_EN
  output logic        misalign_out,
`endif
  output logic        stalled_out
);

  // Last boot counter value before fetch is released.
  localparam logic [BOOT_CNT_W-1:0] BOOT_LAST = BOOT_CNT_W'(BOOT_CYCLES - 1);

  pc_state_e             state_q, state_d;
  logic [BOOT_CNT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic                  stalled_q, stalled_d;
  logic                  load_c;
  logic [XLEN-1:0]       load_pc_c;

`ifdef PC_ALIGN_CHECK_EN
  logic                  misalign_q, misalign_d;

  // Misaligned targets are forced onto a word boundary and flagged.
  assign load_pc_c = align_word(npc);
`else
  assign load_pc_c = npc;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      stalled_q  <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      stalled_q  <= stalled_d;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Next-state and datapath control; flush always outranks stall.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    load_c     = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif

    unique case (state_q)
      BOOT: begin
        // stall/flush are ignored until the boot window closes.
        valid_d    = 1'b0;
        boot_cnt_d = boot_cnt_q + BOOT_CNT_W'(1);
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (flush) begin
          load_c  = 1'b1;
          valid_d = 1'b0;
        end else if (stall) begin
          // PC and valid are held as they are.
          state_d = HOLD;
        end else begin
          load_c  = 1'b1;
          valid_d = 1'b1;
        end
      end

      HOLD: begin
        if (flush) begin
          load_c  = 1'b1;
          valid_d = 1'b0;
          state_d = RUN;
        end else if (!stall) begin
          load_c  = 1'b1;
          valid_d = 1'b1;
          state_d = RUN;
        end
      end

      default: begin
        state_d    = BOOT;
        boot_cnt_d = '0;
        valid_d    = 1'b0;
      end
    endcase

    if (load_c) begin
      pc_d = load_pc_c;
`ifdef PC_ALIGN_CHECK_EN
      if (npc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
`endif
    end
  end

  // stalled_out is registered from the state being entered.
  assign stalled_d = (state_d == HOLD);

  pc_adder u_pc_adder (
    .pc_in (pc_q),
    .sum_c (pc_plus4)
  );

  assign pc_out      = pc_q;
  assign valid_out   = valid_q;
  assign stalled_out = stalled_q;
`ifdef PC_ALIGN_CHECK_EN
  assign misalign_out = misalign_q;
`endif

endmodule : pc_stage

// File: tb/tb_pc_stage.sv
// tb_pc_stage: self-checking bench for pc_stage (directed scenarios plus a
// randomized run against a cycle-level behavioural model).
`timescale 1ns/1ps
module tb_pc_stage;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam int          BOOT_N  = 2;

  logic        clk;
  logic        rst;
  logic [31:0] npc;
  logic        stall;
  logic        flush;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        valid_out;
  logic        stalled_out;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign_out;
`endif

  int vectors;
  int miscompares;

  // Behavioural model: boot cycles remaining, holding flag, PC, valid.
  int          m_boot_left;
  bit          m_holding;
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_mis;

  pc_stage #(
    .RESET_PC    (RST_PC),
    .BOOT_CYCLES (BOOT_N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .npc         (npc),
    .stall       (stall),
    .flush       (flush),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .valid_out   (valid_out),
`ifdef PC_ALIGN_CHECK_EN
    .misalign_out(misalign_out),
`endif
    .stalled_out (stalled_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_boot_left = BOOT_N;
    m_holding   = 1'b0;
    m_pc        = RST_PC;
    m_valid     = 1'b0;
    m_mis       = 1'b0;
  endtask

  task automatic model_load(input logic [31:0] n);
`ifdef PC_ALIGN_CHECK_EN
    m_pc = n & 32'hFFFF_FFFC;
    if (n % 4 != 0) m_mis = 1'b1;
`else
    m_pc = n;
`endif
  endtask

  // One clock of the reference behaviour.
  task automatic model_step(input logic [31:0] n, input bit s, input bit f);
    if (m_boot_left > 0) begin
      m_boot_left = m_boot_left - 1;
    end else if (f) begin
      model_load(n);
      m_valid   = 1'b0;
      m_holding = 1'b0;
    end else if (s) begin
      m_holding = 1'b1;
    end else begin
      model_load(n);
      m_valid   = 1'b1;
      m_holding = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, clock it, sample 1ns after the edge.
  task automatic tick(input logic [31:0] n, input bit s, input bit f);
    npc   = n;
    stall = s;
    flush = f;
    @(posedge clk);
    model_step(n, s, f);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    npc   = 32'h0;
    stall = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    model_reset();
    vectors++;
    if (pc_out !== RST_PC) begin
      miscompares++; $display("FAIL reset_pc: got %h expected %h", pc_out, RST_PC);
    end
    vectors++;
    if (pc_plus4 !== RST_PC + 32'd4) begin
      miscompares++; $display("FAIL reset_pc_plus4: got %h expected %h", pc_plus4, RST_PC + 32'd4);
    end
    vectors++;
    if (valid_out !== 1'b0 || stalled_out !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags: got valid=%b stalled=%b expected 0 0", valid_out, stalled_out);
    end
    do_reset();
  endtask

  task automatic test_boot();
    // stall/flush asserted during boot must be ignored.
    tick(32'h4, 1'b1, 1'b1);
    vectors++;
    if (valid_out !== 1'b0 || pc_out !== RST_PC || stalled_out !== 1'b0) begin
      miscompares++; $display("FAIL boot_cycle1: got pc=%h valid=%b stalled=%b expected %h 0 0", pc_out, valid_out, stalled_out, RST_PC);
    end
    tick(32'h4, 1'b0, 1'b0);
    vectors++;
    if (valid_out !== 1'b0 || pc_out !== RST_PC) begin
      miscompares++; $display("FAIL boot_cycle2: got pc=%h valid=%b expected %h 0", pc_out, valid_out, RST_PC);
    end
    tick(32'h4, 1'b0, 1'b0);
    vectors++;
    if (pc_out !== 32'h4 || valid_out !== 1'b1) begin
      miscompares++; $display("FAIL boot_first_fetch: got pc=%h valid=%b expected 00000004 1", pc_out, valid_out);
    end
    vectors++;
    if (pc_plus4 !== 32'h8) begin
      miscompares++; $display("FAIL boot_pc_plus4: got %h expected 00000008", pc_plus4);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      tick(32'h40, 1'b1, 1'b0);
      vectors++;
      if (stalled_out !== 1'b1 || pc_out !== 32'h4 || valid_out !== 1'b1) begin
        miscompares++; $display("FAIL stall_hold_%0d: got pc=%h stalled=%b valid=%b expected 00000004 1 1", i, pc_out, stalled_out, valid_out);
      end
    end
    tick(32'h40, 1'b0, 1'b0);
    vectors++;
    if (pc_out !== 32'h40 || stalled_out !== 1'b0 || valid_out !== 1'b1) begin
      miscompares++; $display("FAIL stall_release: got pc=%h stalled=%b valid=%b expected 00000040 0 1", pc_out, stalled_out, valid_out);
    end
  endtask

  task automatic test_flush_stall();
    tick(32'h100, 1'b1, 1'b1);
    vectors++;
    if (pc_out !== 32'h100 || valid_out !== 1'b0 || stalled_out !== 1'b0) begin
      miscompares++; $display("FAIL flush_run: got pc=%h valid=%b stalled=%b expected 00000100 0 0", pc_out, valid_out, stalled_out);
    end
    tick(32'h104, 1'b0, 1'b0);
    vectors++;
    if (pc_out !== 32'h104 || valid_out !== 1'b1) begin
      miscompares++; $display("FAIL flush_recover: got pc=%h valid=%b expected 00000104 1", pc_out, valid_out);
    end
    // Flush arriving while in HOLD.
    tick(32'h108, 1'b1, 1'b0);
    tick(32'h200, 1'b1, 1'b1);
    vectors++;
    if (pc_out !== 32'h200 || valid_out !== 1'b0 || stalled_out !== 1'b0) begin
      miscompares++; $display("FAIL flush_hold: got pc=%h valid=%b stalled=%b expected 00000200 0 0", pc_out, valid_out, stalled_out);
    end
  endtask

  task automatic test_wrap();
    tick(32'hFFFF_FFFC, 1'b0, 1'b0);
    vectors++;
    if (pc_out !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0000_0000) begin
      miscompares++; $display("FAIL pc_plus4_wrap: got pc=%h plus4=%h expected fffffffc 00000000", pc_out, pc_plus4);
    end
  endtask

  task automatic test_async_reset();
    tick(32'h300, 1'b0, 1'b0);
    tick(32'h304, 1'b1, 1'b0);
    vectors++;
    if (stalled_out !== 1'b1 || pc_out !== 32'h300) begin
      miscompares++; $display("FAIL pre_reset_hold: got pc=%h stalled=%b expected 00000300 1", pc_out, stalled_out);
    end
    // Assert mid-cycle; outputs must clear without a clock edge.
    npc = 32'h500;
    stall = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (pc_out !== RST_PC || valid_out !== 1'b0 || stalled_out !== 1'b0) begin
      miscompares++; $display("FAIL async_reset: got pc=%h valid=%b stalled=%b expected %h 0 0", pc_out, valid_out, stalled_out, RST_PC);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tick(32'h500, 1'b0, 1'b0);
    tick(32'h500, 1'b0, 1'b0);
    vectors++;
    if (pc_out !== RST_PC || valid_out !== 1'b0) begin
      miscompares++; $display("FAIL reboot_suppress: got pc=%h valid=%b expected %h 0", pc_out, valid_out, RST_PC);
    end
    tick(32'h500, 1'b0, 1'b0);
    vectors++;
    if (pc_out !== 32'h500 || valid_out !== 1'b1) begin
      miscompares++; $display("FAIL reboot_fetch: got pc=%h valid=%b expected 00000500 1", pc_out, valid_out);
    end
  endtask

`ifdef PC_ALIGN_CHECK_EN
  task automatic test_align();
    vectors++;
    if (misalign_out !== 1'b0) begin
      miscompares++; $display("FAIL misalign_initial: got %b expected 0", misalign_out);
    end
    tick(32'h1003, 1'b0, 1'b0);
    vectors++;
    if (pc_out !== 32'h1000 || misalign_out !== 1'b1) begin
      miscompares++; $display("FAIL misalign_load: got pc=%h mis=%b expected 00001000 1", pc_out, misalign_out);
    end
    tick(32'h2000, 1'b0, 1'b0);
    vectors++;
    if (pc_out !== 32'h2000 || misalign_out !== 1'b1) begin
      miscompares++; $display("FAIL misalign_sticky: got pc=%h mis=%b expected 00002000 1", pc_out, misalign_out);
    end
    do_reset();
    vectors++;
    if (misalign_out !== 1'b0) begin
      miscompares++; $display("FAIL misalign_clear: got %b expected 0", misalign_out);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] n;
    bit          s;
    bit          f;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      n = $urandom;
      s = ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 7) == 0);
      tick(n, s, f);
      vectors++;
      if (pc_out !== m_pc || pc_plus4 !== m_pc + 32'd4 || valid_out !== m_valid ||
          stalled_out !== m_holding) begin
        miscompares++;
        $display("FAIL random_%0d: got pc=%h plus4=%h valid=%b stalled=%b expected %h %h %b %b",
                 i, pc_out, pc_plus4, valid_out, stalled_out, m_pc, m_pc + 32'd4, m_valid, m_holding);
      end
`ifdef PC_ALIGN_CHECK_EN
      vectors++;
      if (misalign_out !== m_mis) begin
        miscompares++; $display("FAIL random_mis_%0d: got %b expected %b", i, misalign_out, m_mis);
      end
`endif
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b0;
    npc   = 32'h0;
    stall = 1'b0;
    flush = 1'b0;
    #3;
    test_reset();
    test_boot();
    test_stall();
    test_flush_stall();
    test_wrap();
    test_async_reset();
`ifdef PC_ALIGN_CHECK_EN
    test_align();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pc_stage

// File: doc/pc_stage.md
PC_STAGE -- requirements
Module: pc_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have parameter BOOT_CYCLES, default 2, the number of cycles after reset during which fetch is suppressed (legal range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset, asynchronous and active-high.
REQ-005 SHALL have port npc, input, 32, the next-PC value from the 2-to-1 next-PC select mux output.
REQ-006 SHALL have port stall, input, 1, the request to hold the PC this cycle.
REQ-007 SHALL have port flush, input, 1, the request to load npc and insert one bubble.
REQ-008 SHALL have port pc_out, output, 32, the current fetch PC.
REQ-009 SHALL have port pc_plus4, output, 32, equal to pc_out + 4, feeding the sequential input of the next-PC mux.
REQ-010 SHALL have port valid_out, output, 1, which is high when pc_out is a fetch the downstream IF/ID stage must accept.
REQ-011 SHALL have port stalled_out, output, 1, which is high while in state HOLD.

Function
REQ-012 SHALL implement a three-state FSM with states BOOT, RUN and HOLD.
REQ-013 SHALL, in BOOT, hold pc_out and keep valid_out at 0.
- A 4-bit boot counter increments each cycle.
- When the counter equals BOOT_CYCLES-1, the FSM moves to RUN.
- stall and flush are ignored in BOOT.
REQ-014 SHALL, in RUN with flush=1, load pc_out<=npc, drive valid_out<=0 for the next cycle, and stay in RUN.
REQ-015 SHALL, in RUN with flush=0 and stall=1, hold pc_out and valid_out, and move to HOLD.
REQ-016 SHALL, in RUN with flush=0 and stall=0, load pc_out<=npc and drive valid_out<=1.
REQ-017 SHALL, in HOLD with stall=1 and flush=0, hold all state.
REQ-018 SHALL, in HOLD with stall=0 and flush=0, load pc_out<=npc, drive valid_out<=1, and move to RUN.
REQ-019 SHALL, in HOLD with flush=1, load pc_out<=npc, drive valid_out<=0, and move to RUN regardless of stall.
REQ-020 SHALL give flush priority over stall whenever both are asserted in RUN or HOLD.
REQ-021 SHALL have a latency of one cycle: npc sampled at edge N appears on pc_out after edge N.
REQ-022 SHALL compute pc_plus4 combinationally, modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.

Reset
REQ-023 SHALL, while rst=1, immediately force the following, independent of clk:
- pc_out=RESET_PC, pc_plus4=RESET_PC+4
- valid_out=0, stalled_out=0
- state=BOOT, boot counter=0
- misalign_out=0 (when present)
REQ-024 SHALL, when rst asserts mid-operation (RUN or HOLD), discard any pending npc load and restart the BOOT sequence on deassertion.

Configuration
REQ-025 SHALL, with macro PC_ALIGN_CHECK_EN defined, add output port misalign_out, 1 bit.
- Any npc load with npc[1:0]!=2'b00 loads {npc[31:2],2'b00}.
- misalign_out is set sticky until reset.
REQ-026 SHALL, without PC_ALIGN_CHECK_EN, omit misalign_out and load npc verbatim.

Structure
REQ-027 SHALL take the following from shared package mips_pkg:
- the FSM state enum (BOOT, RUN, HOLD)
- the constant PC_INC=32'd4
- the default reset PC constant
REQ-028 SHALL instantiate one sub-module, pc_adder, a 32-bit +PC_INC adder producing pc_plus4.

Verification
REQ-029 SHALL cover: rst pulse with RESET_PC=0, BOOT_CYCLES=2 -> valid_out=0 for 2 cycles, then with npc=32'h4 pc_out=32'h4 and valid_out=1 on the third edge.
REQ-030 SHALL cover: RUN, stall=1 for 3 cycles with npc=32'h40 -> pc_out held, stalled_out=1 for 3 cycles, pc_out=32'h40 one cycle after stall drops.
REQ-031 SHALL cover: RUN, stall=1 and flush=1 with npc=32'h100 -> pc_out=32'h100, valid_out=0 next cycle, stalled_out=0.
REQ-032 SHALL cover: pc_out=32'hFFFF_FFFC -> pc_plus4=32'h0000_0000.
REQ-033 SHALL cover: rst asserted asynchronously mid-HOLD -> pc_out=RESET_PC and valid_out=0 before the next clk edge.
REQ-034 SHALL cover: with PC_ALIGN_CHECK_EN, npc=32'h1003 in RUN -> pc_out=32'h1000, misalign_out=1 and held until rst.
